// File: rtl/sd_spi_card_responder.sv
// SD card SPI-mode command responder: receives 48-bit command frames from the
// host and answers each accepted frame with NCR filler bytes and an R1 status byte.
module sd_spi_card_responder #(
  parameter int NCR       = 1,
  parameter bit CRC_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_sck,
  input  logic        sd_cmd,
  input  logic        sd_cs_n,
  output logic        sd_dat0,
  output logic        sd_dat0_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        card_idle
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_NCR, S_R1} state_t;

  localparam logic [2:0] NCR_LAST = 3'(NCR - 1);

  state_t      state, state_nx;
  logic        sck_s1, sck_s2, sck_prev;
  logic        cmd_s1, cmd_s2;
  logic        cs_n_s1, cs_n_s2;
  logic        cs_act, sck_rise, sck_fall, byte_end;
  logic [2:0]  bit_cnt;
  logic [5:0]  frame_cnt;
  logic [45:0] frame_sh;
  logic [6:0]  crc;
  logic [2:0]  fill_cnt;
  logic        wait_sync;
  logic        app_flag;
  logic [7:0]  r1_sh;
  logic [46:0] frame;
  logic [5:0]  idx;
  logic        frame_last, frame_ok, crc_bad, illegal, idle_nx;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
    crc7_step = {c[5:0], 1'b0} ^ ((d ^ c[6]) ? 7'h09 : 7'h00);
  endfunction

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values that existed before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      cmd_s1   <= 1'b1;
      cmd_s2   <= 1'b1;
      cs_n_s1  <= 1'b1;
      cs_n_s2  <= 1'b1;
    end else begin
      sck_s1   <= sd_sck;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      cmd_s1   <= sd_cmd;
      cmd_s2   <= cmd_s1;
      cs_n_s1  <= sd_cs_n;
      cs_n_s2  <= cs_n_s1;
    end
  end

  assign cs_act     = ~cs_n_s2;
  assign sd_dat0_oe = cs_act;
  assign sck_rise   = sck_s2 & ~sck_prev;
  assign sck_fall   = ~sck_s2 & sck_prev;
  assign byte_end   = cs_act & sck_rise & (bit_cnt == 3'd7);

  // Frame as seen at the end-bit sample: 46 stored bits plus the live end bit.
  assign frame      = {frame_sh, cmd_s2};
  assign idx        = frame[45:40];
  assign frame_last = cs_act & sck_rise & (state == S_CMD) & (frame_cnt == 6'd46);
  assign frame_ok   = frame[46] & frame[0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    crc_bad  = CRC_CHECK && (crc != frame[7:1]);
    illegal  = 1'b1;
    idle_nx  = card_idle;
    case (idx)
      6'd0, 6'd8, 6'd55, 6'd58: illegal = 1'b0;
      6'd41:                    illegal = ~app_flag;
      default:                  illegal = 1'b1;
    endcase
    if (!crc_bad) begin
      if (idx == 6'd0) idle_nx = 1'b1;
      else if (idx == 6'd41 && app_flag) idle_nx = 1'b0;
    end
    if (!cs_act) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (sck_rise && !cmd_s2) state_nx = S_CMD;
        S_CMD:  if (frame_last) state_nx = frame_ok ? S_NCR : S_IDLE;
        S_NCR:  if (byte_end && !wait_sync && fill_cnt == NCR_LAST) state_nx = S_R1;
        S_R1:   if (byte_end) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      frame_cnt <= '0;
      frame_sh  <= '0;
      crc       <= '0;
      fill_cnt  <= '0;
      wait_sync <= 1'b0;
      app_flag  <= 1'b0;
      r1_sh     <= 8'hFF;
      sd_dat0   <= 1'b1;
      cmd_valid <= 1'b0;
      crc_err   <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      card_idle <= 1'b1;
    end else begin
      cmd_valid <= 1'b0;
      crc_err   <= 1'b0;
      if (!cs_act)       bit_cnt <= '0;
      else if (sck_rise) bit_cnt <= bit_cnt + 3'd1;

      case (state)
        S_IDLE: begin
          frame_cnt <= '0;
          crc       <= '0;
        end
        S_CMD: begin
          if (sck_rise) begin
            frame_sh  <= {frame_sh[44:0], cmd_s2};
            frame_cnt <= frame_cnt + 6'd1;
            if (frame_cnt < 6'd39) crc <= crc7_step(crc, cmd_s2);
          end
          if (frame_last && frame_ok) begin
            cmd_valid <= 1'b1;
            crc_err   <= crc_bad;
            cmd_index <= idx;
            cmd_arg   <= frame[39:8];
            card_idle <= idle_nx;
            app_flag  <= ~crc_bad & (idx == 6'd55);
            r1_sh     <= {4'b0000, crc_bad, illegal, 1'b0, idle_nx};
            // A frame ending mid-byte must first reach a byte boundary.
            wait_sync <= (bit_cnt != 3'd7);
            fill_cnt  <= '0;
          end
        end
        S_NCR: begin
          if (byte_end) begin
            if (wait_sync) wait_sync <= 1'b0;
            else           fill_cnt  <= fill_cnt + 3'd1;
          end
        end
        S_R1: begin
          if (sck_fall) r1_sh <= {r1_sh[6:0], 1'b1};
        end
        default: ;
      endcase

      if (state == S_R1 && cs_act) begin
        if (sck_fall) sd_dat0 <= r1_sh[7];
      end else begin
        sd_dat0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: one DUT with CRC checking and one
// without, both driven by the same SPI host stimulus.
module tb_sd_spi_card_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_sck, sd_cmd, sd_cs_n;
  logic        miso0, oe0, valid0, crc_err0, idle0;
  logic [5:0]  index0;
  logic [31:0] arg0;
  logic        miso1, oe1, valid1, crc_err1, idle1;
  logic [5:0]  index1;
  logic [31:0] arg1;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;
  int crc_cnt     = 0;
  int exp_valid   = 0;

  logic [7:0] ncr_b, r1_a, r1_b, d0, d1;

  sd_spi_card_responder #(.NCR(1), .CRC_CHECK(1'b1)) dut0 (
    .clk(clk), .reset(reset), .sd_sck(sd_sck), .sd_cmd(sd_cmd), .sd_cs_n(sd_cs_n),
    .sd_dat0(miso0), .sd_dat0_oe(oe0), .cmd_valid(valid0), .cmd_index(index0),
    .cmd_arg(arg0), .crc_err(crc_err0), .card_idle(idle0)
  );

  sd_spi_card_responder #(.NCR(1), .CRC_CHECK(1'b0)) dut1 (
    .clk(clk), .reset(reset), .sd_sck(sd_sck), .sd_cmd(sd_cmd), .sd_cs_n(sd_cs_n),
    .sd_dat0(miso1), .sd_dat0_oe(oe1), .cmd_valid(valid1), .cmd_index(index1),
    .cmd_arg(arg1), .crc_err(crc_err1), .card_idle(idle1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid0)   valid_cnt++;
    if (crc_err0) crc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host shifts nbits MSB-first; MISO is captured just before each sck rise.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx0, output logic [7:0] rx1);
    rx0 = 8'h00;
    rx1 = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      sd_cmd = tx[i];
      repeat (8) @(negedge clk);
      rx0[i] = miso0;
      rx1[i] = miso1;
      sd_sck = 1'b1;
      repeat (8) @(negedge clk);
      sd_sck = 1'b0;
    end
    sd_cmd = 1'b1;
  endtask

  task automatic send_cmd(input logic [47:0] f);
    logic [7:0] a, b;
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], 8, a, b);
  endtask

  task automatic send_frame(input logic [47:0] f, output logic [7:0] ncr,
                            output logic [7:0] r1x, output logic [7:0] r1y);
    logic [7:0] unused;
    send_cmd(f);
    xfer(8'hFF, 8, ncr, unused);
    xfer(8'hFF, 8, r1x, r1y);
  endtask

  initial begin
    reset   = 1'b1;
    sd_sck  = 1'b0;
    sd_cmd  = 1'b1;
    sd_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dat0", miso0, 1);
    check("rst_oe", oe0, 0);
    check("rst_valid", valid0, 0);
    check("rst_crc_err", crc_err0, 0);
    check("rst_index", index0, 0);
    check("rst_arg", arg0, 0);
    check("rst_idle", idle0, 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    sd_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("cs_oe", oe0, 1);

    // CMD0
    send_frame(48'h40_00000000_95, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("cmd0_ncr", ncr_b, 8'hFF);
    check("cmd0_r1", r1_a, 8'h01);
    check("cmd0_index", index0, 0);
    check("cmd0_arg", arg0, 0);
    check("cmd0_valid_cnt", valid_cnt, exp_valid);
    check("cmd0_crc_cnt", crc_cnt, 0);

    // CMD8
    send_frame(48'h48_000001AA_87, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("cmd8_r1", r1_a, 8'h01);
    check("cmd8_arg", arg0, 32'h0000_01AA);
    check("cmd8_index", index0, 8);

    // CMD0 with a corrupted CRC byte
    send_frame(48'h40_00000000_97, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("badcrc_r1_chk", r1_a, 8'h09);
    check("badcrc_r1_nochk", r1_b, 8'h01);
    check("badcrc_crc_cnt", crc_cnt, 1);
    check("badcrc_valid_cnt", valid_cnt, exp_valid);

    // CMD17 is not supported: illegal while idle
    send_frame(48'h51_00000000_55, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("cmd17_r1", r1_a, 8'h05);
    check("cmd17_index", index0, 17);

    // CMD41 without a preceding CMD55
    send_frame(48'h69_40000000_77, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("cmd41_noapp_r1", r1_a, 8'h05);
    check("cmd41_noapp_idle", idle0, 1);

    // CMD55 then ACMD41 leaves idle
    send_frame(48'h77_00000000_65, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("cmd55_r1", r1_a, 8'h01);
    send_frame(48'h69_40000000_77, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("acmd41_r1", r1_a, 8'h00);
    check("acmd41_r1_nochk", r1_b, 8'h00);
    check("acmd41_idle", idle0, 0);
    check("acmd41_index", index0, 41);
    check("acmd41_arg", arg0, 32'h4000_0000);
    check("acmd41_valid_cnt", valid_cnt, exp_valid);

    // Partial frame aborted by chip-select deassert after 20 bits
    xfer(8'h40, 8, d0, d1);
    xfer(8'h00, 8, d0, d1);
    xfer(8'h00, 4, d0, d1);
    sd_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_dat0", miso0, 1);
    check("abort_oe", oe0, 0);
    check("abort_valid_cnt", valid_cnt, exp_valid);
    sd_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(48'h40_00000000_95, ncr_b, r1_a, r1_b);
    exp_valid++;
    check("after_abort_r1", r1_a, 8'h01);
    check("after_abort_idle", idle0, 1);
    check("after_abort_valid_cnt", valid_cnt, exp_valid);

    // Reset asserted while the R1 byte is on MISO
    send_cmd(48'h40_00000000_95);
    xfer(8'hFF, 8, ncr_b, d1);
    repeat (8) @(negedge clk);
    check("r1_msb_driven", miso0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_r1_reset_dat0", miso0, 1);
    check("mid_r1_reset_oe", oe0, 0);
    check("mid_r1_reset_valid", valid0, 0);
    reset   = 1'b0;
    sd_cs_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_spi_card_responder.md
SD_SPI_CARD_RESPONDER -- requirements
Module: sd_spi_card_responder

Interface
REQ-001 SHALL have parameter NCR, default 1, giving the number of 0xFF filler bytes (1..8) between the command end bit and the R1 byte.
REQ-002 SHALL have parameter CRC_CHECK, default 1; 1 enables CRC7 checking of received commands.
REQ-003 SHALL have port clk, input, 1, system clock; all logic sits on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port sd_sck, input, 1, SPI clock from the host, asynchronous to clk, at most clk/8.
REQ-006 SHALL have port sd_cmd, input, 1, MOSI from the host.
REQ-007 SHALL have port sd_cs_n, input, 1, chip select (DAT3), active low.
REQ-008 SHALL have port sd_dat0, output, 1, MISO to the host.
REQ-009 SHALL have port sd_dat0_oe, output, 1, MISO drive enable; equals synchronized chip select asserted.
REQ-010 SHALL have port cmd_valid, output, 1, one-cycle pulse when a complete frame is accepted.
REQ-011 SHALL have port cmd_index, output, 6, index of the last accepted frame; held until the next frame.
REQ-012 SHALL have port cmd_arg, output, 32, argument of the last accepted frame; held until the next frame.
REQ-013 SHALL have port crc_err, output, 1, one-cycle pulse coincident with cmd_valid when the CRC7 mismatches.
REQ-014 SHALL have port card_idle, output, 1, the R1 in-idle-state flag.

Function
REQ-015 SHALL pass sd_sck, sd_cmd and sd_cs_n through 2-flop synchronizers; sck edges are detected from the synchronized value and its previous value.
REQ-016 SHALL use SPI mode 0: sample MOSI on the sck rising edge; update MISO on the sck falling edge.
REQ-017 SHALL count bits in a 3-bit counter cleared when cs is asserted; a byte boundary is a count of 7 followed by a rising edge.
REQ-018 SHALL implement the FSM IDLE -> CMD -> NCR -> R1 -> IDLE.
REQ-019 SHALL, in IDLE, enter CMD when MOSI is sampled 0 (start bit) at any bit position.
REQ-020 SHALL, in CMD, shift in 47 further bits: transmission bit, index[5:0], arg[31:0], crc[6:0], end bit.
REQ-021 SHALL discard the frame and return to IDLE without pulsing cmd_valid if the transmission bit is 0 or the end bit is 0.
REQ-022 SHALL compute CRC7 (x^7+x^3+1, init 0) over the first 40 bits.
REQ-023 SHALL treat a CRC mismatch with CRC_CHECK=1 as setting R1 bit3 and pulsing crc_err; with CRC_CHECK=0 the CRC is ignored.
REQ-024 SHALL, on accept, pulse cmd_valid 1 cycle after the end-bit sample, then wait for the next byte boundary and send NCR bytes of 0xFF, then one R1 byte MSB-first.
REQ-025 SHALL form R1 as bit7=0, bit3=crc error, bit2=illegal command, bit0=card_idle after command effect; all other bits 0.
REQ-026 SHALL handle commands as follows: CMD0 sets card_idle; CMD55 sets app flag for the next frame only; ACMD41 (app flag set, index 41) clears card_idle; CMD8 and CMD58 are accepted with no effect; any other index, or index 41 without the app flag, sets the illegal bit.
REQ-027 SHALL make a CRC-error frame have no command effect, clear the app flag, and still report illegal only per REQ-026 index decoding.
REQ-028 SHALL drive sd_dat0 to 1 whenever not in R1, and to 1 after R1 until the next response.
REQ-029 SHALL ignore MOSI during NCR and R1; a start bit is accepted only in IDLE.
REQ-030 SHALL abort to IDLE on cs deassert in any state: drop the partial frame, no cmd_valid, sd_dat0=1, app flag preserved, bit counter cleared.

Reset
REQ-031 SHALL, on reset, set FSM=IDLE, sd_dat0=1, sd_dat0_oe=0, cmd_valid=0, crc_err=0, cmd_index=0, cmd_arg=0, card_idle=1, app flag=0, synchronizers=idle (sck 0, cs_n 1, cmd 1).
REQ-032 SHALL let reset mid-frame or mid-response override everything within one cycle.

Verification
REQ-033 SHALL pass: cs low, CMD0 frame 40 00 00 00 00 95 then 0xFF bytes -> cmd_valid with index 0, arg 0, no crc_err; MISO shows FF then 01.
REQ-034 SHALL pass: CMD8 48 00 00 01 AA 87 -> cmd_arg=0x000001AA, R1=0x01.
REQ-035 SHALL pass: CMD55 77 00 00 00 00 65, then ACMD41 69 40 00 00 00 77 -> R1 0x01 then 0x00; card_idle=0.
REQ-036 SHALL pass: CMD0 with CRC byte 0x97 and CRC_CHECK=1 -> crc_err pulse, R1=0x09; with CRC_CHECK=0 -> R1=0x01.
REQ-037 SHALL pass: CMD17 51 00 00 00 00 55 -> R1=0x05 while idle; CMD41 without CMD55 -> R1 bit2 set.
REQ-038 SHALL pass: cs deasserted after 20 frame bits, then a full CMD0 -> no cmd_valid for the partial frame, correct R1 for CMD0; reset asserted during R1 -> sd_dat0=1 next cycle.
